elevator_timer_ctrl: RTL and testbench

Shared timing controller for the elevator FSM. It owns one prescaler and one tick down-counter, and arbitrates that single timer between two requesters: door-hold and floor-travel. Requesters use a level request/grant handshake and receive a one-cycle done pulse on expiry. It sits between the system clock domain and the elevator main control FSM, and replaces per-function free-running dividers.

---
 rtl/elevator_timer_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_elevator_timer_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_timer_ctrl.sv
// elevator_timer_ctrl
//   Shared timing controller for the elevator FSM. This module owns one
//   prescaler (pcnt) and one tick down-counter (remaining), and it
//   arbitrates that single timer between the door-hold requester and the
//   floor-travel requester. Each requester uses a level request/grant
//   handshake and receives a one-cycle done pulse when its timer expires.
//
// Parameters
//   DIV        system clocks per timer tick (>= 2)
//   DOOR_TICKS ticks loaded for a door grant   (1 .. 65535)
//   MOVE_TICKS ticks loaded for a travel grant (1 .. 65535)
//
// Optional feature
//   TIMER_PAUSE_EN : when defined, adds the `pause` input. While pause is
//                    high in RUN, the countdown is frozen.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   req_door   in   door timer request (level)
//   req_move   in   travel timer request (level)
//   abort      in   cancel the running timer (acts only in RUN)
//   pause      in   freeze countdown (TIMER_PAUSE_EN only)
//   grant_door out  timer owned by the door requester
//   grant_move out  timer owned by the travel requester
//   busy       out  timer running
//   done_door  out  one-cycle door expiry pulse
//   done_move  out  one-cycle travel expiry pulse
//   tick       out  one-cycle pulse when the countdown decrements
//   remaining  out  ticks left in the current run
module elevator_timer_ctrl #(
    parameter int unsigned DIV        = 130208,
    parameter int unsigned DOOR_TICKS = 288,
    parameter int unsigned MOVE_TICKS = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_door,
    input  logic        req_move,
    input  logic        abort,
`ifdef TIMER_PAUSE_EN
    input  logic        pause,
`endif
    output logic        grant_door,
    output logic        grant_move,
    output logic        busy,
    output logic        done_door,
    output logic        done_move,
    output logic        tick,
    output logic [15:0] remaining
);

    localparam int unsigned    PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PCNT_LAST = PW'(DIV - 1);
    localparam logic [15:0]    DOOR_LOAD = 16'(DOOR_TICKS);
    localparam logic [15:0]    MOVE_LOAD = 16'(MOVE_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_DOOR,
        OWN_MOVE
    } owner_t;

    state_t        state, state_nx;
    owner_t        owner, owner_nx;
    owner_t        last_served, last_nx;
    owner_t        pick;
    logic [PW-1:0] pcnt, pcnt_nx;
    logic [15:0]   rem_nx;
    logic          pause_i;
    logic          tick_i;

`ifdef TIMER_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign tick_i = (state == ST_RUN) && (pcnt == PCNT_LAST) && !pause_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_DOOR;
            last_served <= OWN_MOVE;  // door wins the first tie
            pcnt        <= '0;
            remaining   <= '0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            last_served <= last_nx;
            pcnt        <= pcnt_nx;
            remaining   <= rem_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last_served;
        pcnt_nx  = pcnt;
        rem_nx   = remaining;
        pick     = OWN_DOOR;

        case (state)
            ST_IDLE: begin
                if (req_door || req_move) begin
                    // Round-robin: on a tie, the requester not served last wins.
                    if (req_door && (!req_move || last_served == OWN_MOVE))
                        pick = OWN_DOOR;
                    else
                        pick = OWN_MOVE;
                    state_nx = ST_RUN;
                    owner_nx = pick;
                    last_nx  = pick;
                    pcnt_nx  = '0;
                    rem_nx   = (pick == OWN_DOOR) ? DOOR_LOAD : MOVE_LOAD;
                end
            end

            ST_RUN: begin
                // Abort outranks a same-cycle final tick.
                if (abort) begin
                    state_nx = ST_IDLE;
                    pcnt_nx  = '0;
                    rem_nx   = '0;
                end else if (!pause_i) begin
                    pcnt_nx = (pcnt == PCNT_LAST) ? '0 : pcnt + PW'(1);
                    if (tick_i) begin
                        rem_nx = remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state_nx = ST_DONE;
                            pcnt_nx  = '0;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
                pcnt_nx  = '0;
                rem_nx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state/owner only (tick also
    // honours pause, which has to gate the decrement in the same cycle).
    // ------------------------------------------------------------------
    assign busy       = (state == ST_RUN);
    assign grant_door = (state == ST_RUN)  && (owner == OWN_DOOR);
    assign grant_move = (state == ST_RUN)  && (owner == OWN_MOVE);
    assign done_door  = (state == ST_DONE) && (owner == OWN_DOOR);
    assign done_move  = (state == ST_DONE) && (owner == OWN_MOVE);
    assign tick       = tick_i;

    // ------------------------------------------------------------------
    // Internal consistency properties
    // ------------------------------------------------------------------
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        !(grant_door && grant_move));

    a_run_nonzero: assert property (@(posedge clk) disable iff (rst)
        busy |-> (remaining != 16'd0));

    a_done_single: assert property (@(posedge clk) disable iff (rst)
        (done_door || done_move) |=> !(done_door || done_move));

endmodule

// File: tb/tb_elevator_timer_ctrl.sv
// Directed testbench for elevator_timer_ctrl with DIV=4, DOOR_TICKS=3,
// MOVE_TICKS=2. Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point, so every check sees the state
// produced by the preceding edge.
module tb_elevator_timer_ctrl;

    localparam int unsigned DIV        = 4;
    localparam int unsigned DOOR_TICKS = 3;
    localparam int unsigned MOVE_TICKS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_door;
    logic        req_move;
    logic        abort;
`ifdef TIMER_PAUSE_EN
    logic        pause;
`endif
    logic        grant_door;
    logic        grant_move;
    logic        busy;
    logic        done_door;
    logic        done_move;
    logic        tick;
    logic [15:0] remaining;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    elevator_timer_ctrl #(
        .DIV        (DIV),
        .DOOR_TICKS (DOOR_TICKS),
        .MOVE_TICKS (MOVE_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_door   (req_door),
        .req_move   (req_move),
        .abort      (abort),
`ifdef TIMER_PAUSE_EN
        .pause      (pause),
`endif
        .grant_door (grant_door),
        .grant_move (grant_move),
        .busy       (busy),
        .done_door  (done_door),
        .done_move  (done_move),
        .tick       (tick),
        .remaining  (remaining)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        req_door = 1'b0;
        req_move = 1'b0;
        abort    = 1'b0;
`ifdef TIMER_PAUSE_EN
        pause    = 1'b0;
`endif
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gd"},  grant_door, 0);
        check({tag, "_gm"},  grant_move, 0);
        check({tag, "_busy"}, busy,      0);
        check({tag, "_dd"},  done_door,  0);
        check({tag, "_dm"},  done_move,  0);
        check({tag, "_rem"}, remaining,  0);
    endtask

    // Entered at the first cycle of a grant; leaves at the done cycle.
    task automatic run_check(input bit door, input int unsigned n);
        int unsigned ticks;
        ticks = 0;
        for (int unsigned k = 0; k < n * DIV; k++) begin
            check("run_grant", door ? grant_door : grant_move, 1);
            check("run_other", door ? grant_move : grant_door, 0);
            check("run_busy", busy, 1);
            check("run_remaining", remaining, n - k / DIV);
            check("run_tick", tick, (k % DIV) == DIV - 1);
            if (tick) ticks++;
            step;
        end
        check("tick_count", ticks, n);
        check("done_door", done_door, door);
        check("done_move", done_move, !door);
        check("done_gd", grant_door, 0);
        check("done_gm", grant_move, 0);
        check("done_busy", busy, 0);
        check("done_rem", remaining, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at;

        // Reset state
        do_reset;
        check_quiet("reset");
        check("reset_tick", tick, 0);

        // Single door run
        req_door = 1'b1;
        step;
        req_door = 1'b0;
        run_check(1'b1, DOOR_TICKS);
        step;
        check_quiet("after_door");

        // Tie after reset: door first, then move, then door again
        do_reset;
        req_door = 1'b1;
        req_move = 1'b1;
        step;
        req_door = 1'b0;
        run_check(1'b1, DOOR_TICKS);
        step;
        check("gap_gm", grant_move, 0);
        check("gap_busy", busy, 0);
        step;
        check("rr_move_grant", grant_move, 1);
        req_move = 1'b0;
        run_check(1'b0, MOVE_TICKS);
        req_door = 1'b1;
        req_move = 1'b1;
        step;
        check("rr_idle_busy", busy, 0);
        step;
        check("rr_door_again", grant_door, 1);
        check("rr_move_wait", grant_move, 0);
        req_door = 1'b0;
        req_move = 1'b0;
        abort    = 1'b1;
        step;
        abort = 1'b0;
        check_quiet("rr_abort");

        // Abort at remaining=2, pending move granted one cycle later
        do_reset;
        req_door = 1'b1;
        step;
        req_door = 1'b0;
        req_move = 1'b1;
        repeat (4) step;
        check("abort_pre_rem", remaining, 2);
        abort = 1'b1;
        step;
        abort = 1'b0;
        check_quiet("abort");
        step;
        check("abort_move_grant", grant_move, 1);
        check("abort_move_rem", remaining, MOVE_TICKS);
        check("abort_no_done", done_door, 0);
        req_move = 1'b0;
        abort    = 1'b1;
        step;
        abort = 1'b0;

        // Abort coincident with the final tick
        req_door = 1'b1;
        step;
        req_door = 1'b0;
        check("final_grant", grant_door, 1);
        repeat (11) step;
        check("final_tick", tick, 1);
        check("final_rem", remaining, 1);
        abort = 1'b1;
        step;
        abort = 1'b0;
        check_quiet("final_abort");
        step;
        check_quiet("final_after");

        // Reset mid-run with remaining=1 and request still high
        req_door = 1'b1;
        step;
        repeat (8) step;
        check("rst_pre_rem", remaining, 1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check_quiet("midrun_rst");
        check("midrun_rst_tick", tick, 0);
        step;
        check("rst_regrant", grant_door, 1);
        check("rst_regrant_rem", remaining, DOOR_TICKS);
        for (int i = 0; i < 6; i++) begin
            check("rst_no_done", done_door, 0);
            step;
        end
        req_door = 1'b0;
        abort    = 1'b1;
        step;
        abort = 1'b0;

        // Expiry timing, optionally with a 5-cycle pause
        do_reset;
        req_door = 1'b1;
        step;
        req_door = 1'b0;
        done_at  = 999;
        for (int c = 0; c < 30; c++) begin
`ifdef TIMER_PAUSE_EN
            if (c == 3) pause = 1'b1;
            if (c == 8) pause = 1'b0;
            if (c >= 3 && c < 8) check("pause_tick", tick, 0);
`endif
            if (done_door && done_at == 999) done_at = c;
            step;
        end
`ifdef TIMER_PAUSE_EN
        check("done_cycle", done_at, 17);
`else
        check("done_cycle", done_at, 12);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
